// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : Multiplexed common-anode 7-segment scanner with frame-aligned
//            value commit, dead-time anti-ghosting and leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] c_one = NUM_DIGITS'(1);

  logic [CW-1:0]           r_cnt;
  logic [DW-1:0]           r_dig;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shd;
  logic [NUM_DIGITS-1:0]   r_shd_dp;

  logic                    w_cnt_wrap;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic [3:0]              w_nib;
  logic                    w_blank_cur;
  logic                    w_dp_cur;
  logic                    w_drive;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0:    f_glyph = 7'b0000001;
      4'h1:    f_glyph = 7'b1001111;
      4'h2:    f_glyph = 7'b0010010;
      4'h3:    f_glyph = 7'b0000110;
      4'h4:    f_glyph = 7'b1001100;
      4'h5:    f_glyph = 7'b0100100;
      4'h6:    f_glyph = 7'b0100000;
      4'h7:    f_glyph = 7'b0001111;
      4'h8:    f_glyph = 7'b0000000;
      4'h9:    f_glyph = 7'b0000100;
      4'hA:    f_glyph = 7'b0001000;
      4'hB:    f_glyph = 7'b1100000;
      4'hC:    f_glyph = 7'b0110001;
      4'hD:    f_glyph = 7'b1000010;
      4'hE:    f_glyph = 7'b0110000;
      default: f_glyph = 7'b0111000;
    endcase
  endfunction

  assign w_cnt_wrap = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_boundary = w_cnt_wrap && (r_dig == DW'(NUM_DIGITS - 1));

  // A digit is blanked when it and every digit above it holds zero.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run & (r_disp[4*k +: 4] == 4'h0);
      w_blank[k] = blank_lz & w_zero_run;
    end
  end

  always_comb begin
    w_nib       = 4'(r_disp >> {r_dig, 2'b00});
    w_blank_cur = 1'(w_blank >> r_dig);
    w_dp_cur    = 1'(r_disp_dp >> r_dig);
    w_drive     = (r_cnt >= CW'(DEAD_CYCLES)) && !w_blank_cur;
    w_an_nxt    = '1;
    w_seg_nxt   = 7'h7F;
    w_dp_nxt    = 1'b1;
    if (w_drive) begin
      w_an_nxt  = ~(c_one << r_dig);
      w_seg_nxt = f_glyph(w_nib);
      w_dp_nxt  = ~w_dp_cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_dig <= w_boundary ? '0 : r_dig + DW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A load landing on the boundary cycle bypasses the shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp    <= '0;
      r_disp_dp <= '0;
      r_shd     <= '0;
      r_shd_dp  <= '0;
      pending   <= 1'b0;
    end else if (w_boundary) begin
      pending <= 1'b0;
      if (load) begin
        r_disp    <= value_in;
        r_disp_dp <= dp_in;
      end else if (pending) begin
        r_disp    <= r_shd;
        r_disp_dp <= r_shd_dp;
      end
    end else if (load) begin
      r_shd    <= value_in;
      r_shd_dp <= dp_in;
      pending  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= w_an_nxt;
      seg_n      <= w_seg_nxt;
      dp_n       <= w_dp_nxt;
      frame_tick <= w_boundary;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Self-checking bench for seven_seg_scanner (4 digits, 8-cycle slots).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  seven_seg_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .load      (load),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        bl;
    logic [3:0]  lit;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       pend;
  } obs_t;

  obs_t q[$];
  vec_t tbl[8];
  vec_t v_zero, v_2222, v_00c5;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int idx, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One expected sample per cycle of the next frame, slot j = cycle j after the boundary.
  task automatic push_frame(input vec_t v);
    obs_t o;
    for (int j = 0; j < 32; j++) begin
      int c = j % 8;
      int d = j / 8;
      o.an   = 4'hF;
      o.seg  = 7'h7F;
      o.dp   = 1'b1;
      o.ft   = (j == 31);
      o.pend = 1'b0;
      if (c >= 2 && v.lit[d]) begin
        o.an     = 4'hF;
        o.an[d]  = 1'b0;
        o.seg    = v.segs[7*d +: 7];
        o.dp     = ~v.dp[d];
      end
      q.push_back(o);
    end
  endtask

  task automatic check_frame(input string nm);
    obs_t e, a;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      a = '{an: an_n, seg: seg_n, dp: dp_n, ft: frame_tick, pend: pending};
      if (q.size() == 0) begin
        chk({nm, "_empty"}, j, 14'h0, 14'h1);
      end else begin
        e = q.pop_front();
        chk(nm, j, a, e);
      end
    end
  endtask

  task automatic wait_tick(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    chk({nm, "_tick_timeout"}, 0, 14'(seen), 14'h1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    v_zero = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {4{7'b0000001}}};
    v_2222 = '{16'h2222, 4'b0000, 1'b0, 4'b1111, {4{7'b0010010}}};
    v_00c5 = '{16'h00C5, 4'b0000, 1'b0, 4'b1111, {7'b0000001, 7'b0000001, 7'b0110001, 7'b0100100}};
    tbl[0] = '{16'h3A7F, 4'b0100, 1'b0, 4'b1111, {7'b0000110, 7'b0001000, 7'b0001111, 7'b0111000}};
    tbl[1] = '{16'h0005, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b0100100}};
    tbl[2] = '{16'h0000, 4'b0001, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
    tbl[3] = '{16'h00C5, 4'b0000, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'b0110001, 7'b0100100}};
    tbl[4] = '{16'h0809, 4'b1111, 1'b1, 4'b0111, {7'h7F, 7'b0000000, 7'b0000001, 7'b0000100}};
    tbl[5] = '{16'hBCDE, 4'b0001, 1'b0, 4'b1111, {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}};
    tbl[6] = '{16'h9642, 4'b1000, 1'b1, 4'b1111, {7'b0000100, 7'b0100000, 7'b1001100, 7'b0010010}};
    tbl[7] = '{16'h0181, 4'b0010, 1'b0, 4'b1111, {7'b0000001, 7'b1001111, 7'b0000000, 7'b1001111}};

    rst = 1'b1; value_in = '0; load = 1'b0; dp_in = '0; blank_lz = 1'b0;
    cyc(3);
    chk("reset_outputs", 0, {an_n, seg_n, dp_n, frame_tick, pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});

    // First drive after reset appears in post-reset cycle 3.
    rst = 1'b0;
    push_frame(v_zero);
    check_frame("post_reset");

    for (int i = 0; i < 8; i++) begin
      cyc(4);
      blank_lz = tbl[i].bl;
      do_load(tbl[i].val, tbl[i].dp);
      chk("pending_set", i, 14'(pending), 14'h1);
      push_frame(tbl[i]);
      wait_tick("table");
      chk("pending_clr", i, 14'(pending), 14'h0);
      check_frame("table_frame");
    end

    cyc(3);
    blank_lz = 1'b0;
    do_load(16'h1111, 4'b0000);
    cyc(5);
    do_load(16'h2222, 4'b0000);
    chk("two_load_pending", 0, 14'(pending), 14'h1);
    push_frame(v_2222);
    wait_tick("two_load");
    check_frame("two_load_frame");

    // Load presented in the boundary cycle itself.
    cyc(31);
    value_in = 16'h00C5;
    dp_in    = 4'b0000;
    load     = 1'b1;
    push_frame(v_00c5);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("bypass_tick", 0, {12'h0, frame_tick, pending}, {12'h0, 1'b1, 1'b0});
    check_frame("bypass_frame");

    // Reset during digit 2 drive phase with a value pending.
    cyc(5);
    do_load(16'h7777, 4'b1111);
    chk("rst_pre_pending", 0, 14'(pending), 14'h1);
    cyc(14);
    chk("rst_pre_an", 0, 14'(an_n), 14'(4'b1011));
    rst = 1'b1;
    #1;
    chk("rst_async", 0, {an_n, seg_n, dp_n, frame_tick, pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    push_frame(v_zero);
    check_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
